// File: rtl/dmem_be_if.sv
// Access bus between the MEM stage and the byte-enabled data memory.
interface dmem_be_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] ad;
  logic [31:0] wData;
  logic [31:0] rData;
  logic        ack;
  logic        misalign;
  logic        busy;

  // MEM stage side
  modport master (
    output req, we, size, sext, ad, wData,
    input  rData, ack, misalign, busy
  );

  // memory side
  modport slave (
    input  req, we, size, sext, ad, wData,
    output rData, ack, misalign, busy
  );
endinterface

// File: rtl/dmem_be.sv
// Byte-addressable data memory: lane writes, extended sub-word loads,
// misalignment flagging, registered read with ack, post-reset clear sweep.
module dmem_be #(
  parameter int unsigned MEMSIZE = 128,
  parameter int unsigned DQ_W    = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_be_if.slave        bus,
  input  logic [DQ_W-1:0] DMQUERY,
  output logic [31:0]     DMOUT
);

  localparam int unsigned IW = $clog2(MEMSIZE);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t         state;
  logic [IW-1:0]  cnt;
  logic [31:0]    mem [MEMSIZE];

  logic           ack_q;
  logic           mis_q;
  logic           busy_q;
  logic [31:0]    rdata_q;

  logic           accept_c;
  logic [IW-1:0]  widx_c;
  logic [IW-1:0]  qidx_c;
  logic [1:0]     off_c;
  logic           mis_c;
  logic [3:0]     be_c;
  logic [31:0]    wd_c;
  logic [31:0]    word_c;
  logic [7:0]     lane_b_c;
  logic [15:0]    lane_h_c;
  logic [31:0]    ld_c;
  logic           unused_bits;

  // Address decode; upper address bits wrap modulo MEMSIZE words
  assign widx_c      = IW'(bus.ad >> 2);
  assign qidx_c      = IW'(DMQUERY >> 2);
  assign off_c       = bus.ad[1:0];
  assign accept_c    = (state == RUN) && bus.req;
  assign word_c      = mem[widx_c];
  assign DMOUT       = mem[qidx_c];
  assign unused_bits = ^{bus.ad, DMQUERY};

  // Alignment check and store lane enables / replicated store data
  always_comb begin
    mis_c = 1'b0;
    be_c  = 4'b0000;
    wd_c  = bus.wData;
    case (bus.size)
      2'b00: begin
        be_c = 4'(4'b0001 << off_c);
        wd_c = {4{bus.wData[7:0]}};
      end
      2'b01: begin
        mis_c = off_c[0];
        be_c  = off_c[1] ? 4'b1100 : 4'b0011;
        wd_c  = {2{bus.wData[15:0]}};
      end
      2'b10: begin
        mis_c = |off_c;
        be_c  = 4'b1111;
      end
      default: mis_c = 1'b1;
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    lane_b_c = 8'(word_c >> {off_c, 3'b000});
    lane_h_c = off_c[1] ? word_c[31:16] : word_c[15:0];
    ld_c     = '0;
    case (bus.size)
      2'b00:   ld_c = bus.sext ? {{24{lane_b_c[7]}}, lane_b_c} : {24'b0, lane_b_c};
      2'b01:   ld_c = bus.sext ? {{16{lane_h_c[15]}}, lane_h_c} : {16'b0, lane_h_c};
      2'b10:   ld_c = word_c;
      default: ld_c = '0;
    endcase
  end

  // Sweep/run state and registered access results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      cnt     <= '0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        CLEAR: begin
          cnt <= cnt + IW'(1);
          if (cnt == IW'(MEMSIZE - 1)) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        default: begin
          if (bus.req) begin
            ack_q   <= 1'b1;
            mis_q   <= mis_c;
            rdata_q <= (mis_c || bus.we) ? 32'h0 : ld_c;
          end
        end
      endcase
    end
  end

  // Array writes: sweep zeroing, then aligned lane stores; none in reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (accept_c && bus.we && !mis_c) begin
        for (int b = 0; b < 4; b++) begin
          if (be_c[b]) mem[widx_c][8*b +: 8] <= wd_c[8*b +: 8];
        end
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.misalign = mis_q;
  assign bus.busy     = busy_q;
  assign bus.rData    = rdata_q;

endmodule

// File: tb/tb_dmem_be.sv
// Directed bench for dmem_be: vector table plus sweep, back-to-back and reset sequences.
module tb_dmem_be;

  localparam int unsigned MEMSIZE = 128;
  localparam int unsigned DQ_W    = 10;

  logic            clk;
  logic            rst_n;
  logic [DQ_W-1:0] DMQUERY;
  logic [31:0]     DMOUT;

  int errors = 0;
  int checks = 0;

  dmem_be_if bus ();

  dmem_be #(.MEMSIZE(MEMSIZE), .DQ_W(DQ_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .DMQUERY (DMQUERY),
    .DMOUT   (DMOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [1:0]      size;
    logic            sext;
    logic [31:0]     ad;
    logic [31:0]     wd;
    logic [31:0]     exp_r;
    logic            exp_mis;
    logic [DQ_W-1:0] q;
    logic [31:0]     exp_q;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.size  = 2'b10;
    bus.sext  = 1'b0;
    bus.ad    = '0;
    bus.wData = '0;
  endtask

  // Counts edges after reset release; busy must fall at exactly edge MEMSIZE
  task automatic sweep_check(input bit req_at_5);
    for (int k = 1; k <= int'(MEMSIZE); k++) begin
      bus.req = (req_at_5 && k == 5);
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      if (k == 5 || k >= int'(MEMSIZE) - 1) begin
        chk($sformatf("busy_edge%0d", k), 32'(bus.busy), (k < int'(MEMSIZE)) ? 32'h1 : 32'h0);
        chk($sformatf("ack_edge%0d", k), 32'(bus.ack), 32'h0);
      end else if (bus.busy !== 1'b1 || bus.ack !== 1'b0) begin
        chk($sformatf("sweep_edge%0d", k), {30'b0, bus.busy, bus.ack}, 32'h2);
      end
    end
  endtask

  // One accepted access; results checked in the cycle after the edge
  task automatic access(input vec_t v, input string name);
    bus.req   = 1'b1;
    bus.we    = v.we;
    bus.size  = v.size;
    bus.sext  = v.sext;
    bus.ad    = v.ad;
    bus.wData = v.wd;
    @(posedge clk);
    @(negedge clk);
    idle();
    chk({name, "_ack"}, 32'(bus.ack), 32'h1);
    chk({name, "_rdata"}, bus.rData, v.exp_r);
    chk({name, "_mis"}, 32'(bus.misalign), 32'(v.exp_mis));
    DMQUERY = v.q;
    #1;
    chk({name, "_dmout"}, DMOUT, v.exp_q);
  endtask

  initial begin
    rst_n   = 1'b0;
    DMQUERY = '0;
    idle();

    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10,  32'h8899AABB, 32'h0,        1'b0, 10'h10, 32'h8899AABB});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h10,  32'h0,        32'hFFFFFFBB, 1'b0, 10'h10, 32'h8899AABB});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        32'hFFFFFFAA, 1'b0, 10'h10, 32'h8899AABB});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'hFFFFFF88, 1'b0, 10'h10, 32'h8899AABB});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h12,  32'h0,        32'h00000099, 1'b0, 10'h10, 32'h8899AABB});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h22,  32'h00001234, 32'h0,        1'b0, 10'h20, 32'h12340000});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h12340000, 1'b0, 10'h20, 32'h12340000});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'h00001234, 1'b0, 10'h20, 32'h12340000});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h20,  32'h00008001, 32'h0,        1'b0, 10'h20, 32'h12348001});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h20,  32'h0,        32'hFFFF8001, 1'b0, 10'h20, 32'h12348001});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        32'h00001234, 1'b0, 10'h20, 32'h12348001});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h21,  32'hFFFFFF5A, 32'h0,        1'b0, 10'h20, 32'h12345A01});
    vecs.push_back('{1'b0, 2'b10, 1'b1, 32'h20,  32'h0,        32'h12345A01, 1'b0, 10'h20, 32'h12345A01});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h06,  32'h0,        32'h0,        1'b1, 10'h04, 32'h0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h05,  32'h0,        32'h0,        1'b1, 10'h04, 32'h0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h00,  32'hFFFFFFFF, 32'h0,        1'b1, 10'h00, 32'h0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h06,  32'hFFFFFFFF, 32'h0,        1'b1, 10'h04, 32'h0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h13,  32'h0000FFFF, 32'h0,        1'b1, 10'h10, 32'h8899AABB});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h240, 32'hCAFEF00D, 32'h0,        1'b0, 10'h40, 32'hCAFEF00D});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h40,  32'h0,        32'hCAFEF00D, 1'b0, 10'h40, 32'hCAFEF00D});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h43,  32'h0,        32'h000000CA, 1'b0, 10'h40, 32'hCAFEF00D});

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'h1);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_rdata", bus.rData, 32'h0);
    chk("rst_mis", 32'(bus.misalign), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep with a request dropped at edge 5
    sweep_check(1'b1);
    for (int i = 0; i < 256; i++) begin
      DMQUERY = DQ_W'(i * 4);
      #0.1;
      chk($sformatf("clear_q%0h", i * 4), DMOUT, 32'h0);
    end

    // Directed vector table
    foreach (vecs[i]) access(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back store then load with req held high
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.ad = 32'h40; bus.wData = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_ack1", 32'(bus.ack), 32'h1);
    chk("b2b_rdata1", bus.rData, 32'h0);
    bus.we = 1'b0; bus.wData = 32'h0;
    @(posedge clk);
    @(negedge clk);
    idle();
    chk("b2b_ack2", 32'(bus.ack), 32'h1);
    chk("b2b_rdata2", bus.rData, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_ack_drop", 32'(bus.ack), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_rdata", bus.rData, 32'hDEADBEEF);
    chk("hold_mis", 32'(bus.misalign), 32'h0);

    // Misaligned load after real data: flag set, rData cleared
    access('{1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 10'h40, 32'hDEADBEEF}, "mis_after_load");
    @(negedge clk);
    chk("hold_mis_flag", 32'(bus.misalign), 32'h1);

    // Reset pulsed during the cycle after a load request
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.ad = 32'h10;
    @(posedge clk);
    #2;
    idle();
    chk("prerst_ack", 32'(bus.ack), 32'h1);
    chk("prerst_rdata", bus.rData, 32'h8899AABB);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(bus.ack), 32'h0);
    chk("midrst_rdata", bus.rData, 32'h0);
    chk("midrst_mis", 32'(bus.misalign), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check(1'b0);
    DMQUERY = 10'h10; #1; chk("resweep_q10", DMOUT, 32'h0);
    DMQUERY = 10'h20; #1; chk("resweep_q20", DMOUT, 32'h0);
    DMQUERY = 10'h40; #1; chk("resweep_q40", DMOUT, 32'h0);
    @(negedge clk);
    access('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 10'h40, 32'h0}, "post_sweep_lw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
